// File: rtl/rr_mux_pkg.sv
// ============================================================================
// Module      : rr_mux_pkg
// Description : Shared constants, types and helpers for the 4:1 round-robin
//               packet multiplexer (rr_mux_4to1) and its arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rr_mux_pkg;

  // Number of input channels and width of a channel index.
  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  // Channel index type.
  typedef logic [SEL_W-1:0] sel_t;

  // One-hot decode of a channel index.
  function automatic logic [NUM_CH-1:0] onehot(input sel_t idx);
    logic [NUM_CH-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage : rr_mux_pkg

`default_nettype wire

// File: rtl/rr_arbiter_4.sv
// ============================================================================
// Module      : rr_arbiter_4
// Description : Four-way rotating-priority arbiter. Searches upward from the
//               round-robin pointer (mod 4) for the first requester and moves
//               the pointer just past the winner whenever a grant is issued.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter_4
  import rr_mux_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] i_req,        // already masked requests
  input  logic              i_en,         // grant allowed this cycle
  output logic [NUM_CH-1:0] o_grant,      // one-hot or zero
  output sel_t              o_grant_idx,  // index of the granted channel
  output logic              o_grant_vld   // a grant is issued (beat accepted)
);

  sel_t r_rr_ptr;

  logic [NUM_CH-1:0] w_grant;
  sel_t              w_grant_idx;
  logic              w_grant_vld;

  // Priority search starting at the pointer; the first hit wins.
  always_comb begin
    sel_t w_cand;
    w_grant     = '0;
    w_grant_idx = '0;
    w_grant_vld = 1'b0;
    w_cand      = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      w_cand = r_rr_ptr + sel_t'(k);
      if (i_en && !w_grant_vld && i_req[w_cand]) begin
        w_grant_vld = 1'b1;
        w_grant_idx = w_cand;
        w_grant     = onehot(w_cand);
      end
    end
  end

  // Pointer moves past the winner on every grant; holds when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= '0;
    end else if (w_grant_vld) begin
      r_rr_ptr <= w_grant_idx + sel_t'(1);
    end
  end

  assign o_grant     = w_grant;
  assign o_grant_idx = w_grant_idx;
  assign o_grant_vld = w_grant_vld;

endmodule : rr_arbiter_4

`default_nettype wire

// File: rtl/rr_mux_4to1.sv
// ============================================================================
// Module      : rr_mux_4to1
// Description : 4:1 round-robin beat multiplexer with a single output
//               register (latency 1, one beat per cycle). The output register
//               empties and reloads in the same cycle when out_ready is high.
//               Optional macro RR_MUX_PKT_LOCK_EN keeps the grant on a channel
//               from its first beat until its in_last beat, so packets are
//               never interleaved. Without it every beat re-arbitrates.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_mux_4to1
  import rr_mux_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        in_valid,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [NUM_CH-1:0]        in_last,
  output logic [NUM_CH-1:0]        in_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [SEL_W-1:0]         out_sel,
  output logic                     out_last,
  input  logic                     out_ready
);

  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  sel_t              r_out_sel;
  logic              r_out_last;

  logic              w_load_en;
  logic [NUM_CH-1:0] w_lock_mask;
  logic [NUM_CH-1:0] w_req;
  logic [NUM_CH-1:0] w_grant;
  sel_t              w_grant_idx;
  logic              w_grant_vld;
  logic [DATA_W-1:0] w_sel_data;
  logic              w_sel_last;

  // The register can take a new beat when empty or draining this cycle.
  assign w_load_en = !r_out_valid | out_ready;
  assign w_req     = in_valid & w_lock_mask;

  rr_arbiter_4 u_arb (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_req       (w_req),
    .i_en        (w_load_en),
    .o_grant     (w_grant),
    .o_grant_idx (w_grant_idx),
    .o_grant_vld (w_grant_vld)
  );

  // No channel may see ready while the block is held in reset.
  assign in_ready = w_grant & {NUM_CH{rst_n}};

  // Select the granted channel's data and last flag.
  always_comb begin
    w_sel_data = '0;
    w_sel_last = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (w_grant_idx == sel_t'(k)) begin
        w_sel_data = in_data[k*DATA_W +: DATA_W];
        w_sel_last = in_last[k];
      end
    end
  end

`ifdef RR_MUX_PKT_LOCK_EN
  logic r_lock;
  sel_t r_lock_ch;

  // Open a lock on a non-last beat, release it on the last beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lock    <= 1'b0;
      r_lock_ch <= '0;
    end else if (w_grant_vld) begin
      r_lock    <= !w_sel_last;
      r_lock_ch <= w_grant_idx;
    end
  end

  // While locked only the owning channel may request, even if it is idle.
  always_comb begin
    w_lock_mask = '1;
    if (r_lock) begin
      w_lock_mask = onehot(r_lock_ch);
    end
  end
`else
  assign w_lock_mask = '1;
`endif

  // Output register: load on grant, clear when drained with nothing granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sel   <= '0;
      r_out_last  <= 1'b0;
    end else if (w_load_en) begin
      r_out_valid <= w_grant_vld;
      if (w_grant_vld) begin
        r_out_data <= w_sel_data;
        r_out_sel  <= w_grant_idx;
        r_out_last <= w_sel_last;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sel   = r_out_sel;
  assign out_last  = r_out_last;

endmodule : rr_mux_4to1

`default_nettype wire

// File: tb/tb_rr_mux_4to1.sv
// ============================================================================
// Module      : tb_rr_mux_4to1
// Description : Self-checking bench for rr_mux_4to1. Expected beats are
//               queued as stimulus is driven and compared as the output
//               register hands them downstream. With RR_MUX_PKT_LOCK_EN the
//               packet-lock sequence is exercised, otherwise interleaving.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rr_mux_4to1;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [3:0]    in_valid;
  logic [4*DW-1:0] in_data;
  logic [3:0]    in_last;
  logic [3:0]    in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [1:0]    out_sel;
  logic          out_last;
  logic          out_ready;

  int checks = 0;
  int errors = 0;
  logic [10:0] sb_q[$];

  always #5 clk = ~clk;

  rr_mux_4to1 #(.DATA_W(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_last  (out_last),
    .out_ready (out_ready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int ch, input logic [7:0] d, input logic l);
    logic [1:0] c;
    c = ch[1:0];
    sb_q.push_back({c, d, l});
  endtask

  task automatic set_data(input int ch, input logic [7:0] d);
    in_data[ch*DW +: DW] = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Output transfers happen at the next rising edge; compare against the queue.
  always @(negedge clk) begin
    logic [10:0] exp_beat;
    if (rst_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        check("unexpected_beat", 32'(sb_q.size()), 32'd1);
      end else begin
        exp_beat = sb_q.pop_front();
        check("beat", {21'd0, out_sel, out_data, out_last}, {21'd0, exp_beat});
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 4'hF;
    in_last   = 4'h0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) set_data(i, 8'hC0 + 8'(i));

    // Reset: everything quiet even with all channels valid.
    repeat (3) tick();
    check("rst_in_ready",  32'(in_ready),  32'h0);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_out_data",  32'(out_data),  32'h0);
    check("rst_out_sel",   32'(out_sel),   32'h0);
    check("rst_rr_ptr",    32'(dut.u_arb.r_rr_ptr), 32'h0);

    // Fairness: 8 cycles of all-valid gives 0,1,2,3,0,1,2,3.
    rst_n = 1'b1;
    #1;
    check("first_grant", 32'(in_ready), 32'h1);
    for (int i = 0; i < 8; i++) push(i % 4, 8'hC0 + 8'(i % 4), 1'b0);
    repeat (8) tick();
    in_valid = 4'h0;
    #1;
    check("idle_no_ready", 32'(in_ready), 32'h0);
    tick();
    tick();
    check("idle_ptr_hold", 32'(dut.u_arb.r_rr_ptr), 32'h0);
    check("drained", 32'(out_valid), 32'h0);

    // Single channel 2.
    set_data(2, 8'hA5);
    in_valid = 4'b0100;
    #1;
    check("single_ready", 32'(in_ready), 32'h4);
    push(2, 8'hA5, 1'b0);
    tick();
    in_valid = 4'h0;
    #1;
    check("single_valid", 32'(out_valid), 32'h1);
    check("single_data",  32'(out_data),  32'hA5);
    check("single_sel",   32'(out_sel),   32'h2);
    check("single_ptr",   32'(dut.u_arb.r_rr_ptr), 32'h3);
    tick();

    // Wrap and skip: pointer 3, channels 0 and 1 valid.
    in_valid = 4'b0011;
    #1;
    check("wrap_ready0", 32'(in_ready), 32'h1);
    push(0, 8'hC0, 1'b0);
    tick();
    check("wrap_ready1", 32'(in_ready), 32'h2);
    push(1, 8'hC1, 1'b0);
    tick();
    in_valid = 4'h0;
    #1;
    check("wrap_sel", 32'(out_sel), 32'h1);
    tick();

    // Backpressure: hold ch1/3C for 5 cycles, then accept ch3 on release.
    set_data(1, 8'h3C);
    in_valid  = 4'b0010;
    out_ready = 1'b0;
    push(1, 8'h3C, 1'b0);
    tick();
    set_data(3, 8'h5A);
    in_valid = 4'b1000;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_in_ready", 32'(in_ready),  32'h0);
      check("bp_valid",    32'(out_valid), 32'h1);
      check("bp_sel",      32'(out_sel),   32'h1);
      check("bp_data",     32'(out_data),  32'h3C);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(in_ready), 32'h8);
    push(3, 8'h5A, 1'b0);
    tick();
    in_valid = 4'h0;
    #1;
    check("bp_next_sel",  32'(out_sel),  32'h3);
    check("bp_next_data", 32'(out_data), 32'h5A);
    tick();

    // Packet on ch1 with ch2 valid throughout (pointer is 0 here).
    set_data(1, 8'h01);
    set_data(2, 8'h2F);
    in_valid = 4'b0110;
    #1;
    check("pkt_first", 32'(in_ready), 32'h2);
    push(1, 8'h01, 1'b0);
    tick();
`ifdef RR_MUX_PKT_LOCK_EN
    in_valid = 4'b0100;
    #1;
    check("lock_gap", 32'(in_ready), 32'h0);
    tick();
    in_valid = 4'b0110;
    set_data(1, 8'h02);
    #1;
    check("lock_beat2", 32'(in_ready), 32'h2);
    push(1, 8'h02, 1'b0);
    tick();
    set_data(1, 8'h03);
    in_last = 4'b0010;
    #1;
    check("lock_beat3", 32'(in_ready), 32'h2);
    push(1, 8'h03, 1'b1);
    tick();
    in_last  = 4'h0;
    in_valid = 4'b0100;
    #1;
    check("lock_release", 32'(in_ready), 32'h4);
    push(2, 8'h2F, 1'b0);
    tick();
`else
    in_valid = 4'b0100;
    #1;
    check("interleave", 32'(in_ready), 32'h4);
    push(2, 8'h2F, 1'b0);
    tick();
    in_valid = 4'b0110;
    set_data(1, 8'h02);
    in_last = 4'b0010;
    #1;
    check("pkt_last_beat", 32'(in_ready), 32'h2);
    push(1, 8'h02, 1'b1);
    tick();
    in_last = 4'h0;
`endif
    in_valid = 4'h0;
    tick();

    // Mid-operation reset discards the held beat immediately.
    set_data(0, 8'hC0);
    in_valid  = 4'b0001;
    out_ready = 1'b0;
    tick();
    check("pre_rst_valid", 32'(out_valid), 32'h1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'h0);
    check("mid_rst_data",  32'(out_data),  32'h0);
    check("mid_rst_ready", 32'(in_ready),  32'h0);
    check("mid_rst_ptr",   32'(dut.u_arb.r_rr_ptr), 32'h0);
    tick();
    in_valid  = 4'h0;
    out_ready = 1'b1;
    rst_n     = 1'b1;
    tick();
    tick();
    check("post_rst_valid", 32'(out_valid), 32'h0);
    check("sb_empty", 32'(sb_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_rr_mux_4to1

`default_nettype wire

// File: doc/rr_mux_4to1.md
RR_MUX_4TO1 -- requirements
Module: rr_mux_4to1

Interface
REQ-001 SHALL have parameter DATA_W, default 8, giving the per-channel data width in bits.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port in_valid, input, 4, per-channel beat valid; bit i belongs to channel i.
REQ-005 SHALL have port in_data, input, 4*DATA_W, channel i data at bits [i*DATA_W +: DATA_W].
REQ-006 SHALL have port in_last, input, 4, per-channel end-of-packet flag.
REQ-007 SHALL have port in_ready, output, 4, per-channel accept; one-hot or zero.
REQ-008 SHALL have port out_valid, output, 1, the output register holds a beat.
REQ-009 SHALL have port out_data, output, DATA_W, data of the held beat.
REQ-010 SHALL have port out_sel, output, 2, source channel index of the held beat.
REQ-011 SHALL have port out_last, output, 1, in_last of the held beat.
REQ-012 SHALL have port out_ready, input, 1, downstream accept.

Function
REQ-013 SHALL transfer a beat on a channel when in_valid[i] and in_ready[i] are both high at a rising edge, and on the output when out_valid and out_ready are both high.
REQ-014 SHALL define load_en = !out_valid | out_ready, so a full output register empties and reloads in one cycle, giving one beat per cycle throughput.
REQ-015 SHALL grant, when load_en is high, the first channel with in_valid high, searching from rr_ptr upward modulo 4; in_ready SHALL be one-hot on that channel, otherwise all zero.
REQ-016 SHALL keep in_ready combinational from in_valid, rr_ptr, lock state and out_ready; it SHALL NOT depend on in_data.
REQ-017 SHALL latch in_data, in_last and the grant index into out_data, out_last and out_sel on an accepted beat; out_valid SHALL rise the next cycle, giving a latency of 1 cycle.
REQ-018 SHALL clear out_valid after an output transfer when no input is granted in the same cycle.
REQ-019 SHALL hold out_data, out_sel and out_last stable while out_valid is high and out_ready is low.
REQ-020 SHALL set rr_ptr to (granted index + 1) mod 4 after each accepted beat, wrapping 3 to 0; it SHALL hold when nothing is accepted.
REQ-021 SHALL, when all in_valid bits are low, assert no in_ready and leave rr_ptr unchanged.
REQ-022 SHALL, with all four channels continuously valid and out_ready high, serve channels in the order 0,1,2,3,0,... from reset.

Reset
REQ-023 SHALL, while rst_n is low, force out_valid=0, out_data=0, out_sel=0, out_last=0, rr_ptr=0 and lock cleared, regardless of clk.
REQ-024 SHALL discard any held beat or partial packet when reset is asserted mid-operation; in_ready SHALL be all zero while rst_n is low.

Configuration
REQ-025 SHALL, when RR_MUX_PKT_LOCK_EN is defined, keep the grant on a channel from its first accepted beat until the beat with in_last=1 is accepted, so packets are never interleaved; the other channels SHALL NOT be granted during that time even if the locked channel's in_valid is low.
REQ-026 SHALL, when RR_MUX_PKT_LOCK_EN is undefined, re-arbitrate on every beat; in_last SHALL only be forwarded to out_last.

Structure
REQ-027 SHALL place NUM_CH=4, SEL_W=2 and typedef sel_t (logic [1:0]) in package rr_mux_pkg.
REQ-028 SHALL implement the rotating-priority grant and rr_ptr in a sub-module rr_arbiter_4; the output register, lock logic and data muxing SHALL live in rr_mux_4to1.

Verification
REQ-029 SHALL check reset: with rst_n=0, in_valid=4'hF and out_ready=1, the bench sees in_ready=0 and out_valid=0; after release the first grant is channel 0.
REQ-030 SHALL check single channel: with in_valid=4'b0100, in_data ch2=8'hA5 and out_ready=1, the bench sees out_valid=1, out_data=8'hA5 and out_sel=2 one cycle later, and rr_ptr=3.
REQ-031 SHALL check fairness: with in_valid=4'hF for 8 cycles and out_ready=1, the bench sees out_sel sequence 0,1,2,3,0,1,2,3.
REQ-032 SHALL check backpressure: with out_ready=0 for 5 cycles while a beat (out_sel=1, out_data=8'h3C) is held, the output stays stable and in_ready=0; on out_ready=1 the next beat is accepted in the same cycle.
REQ-033 SHALL check wrap and skip: with rr_ptr=3 and in_valid=4'b0011, the bench sees channel 0 granted, then channel 1.
REQ-034 SHALL check lock, with RR_MUX_PKT_LOCK_EN defined: a 3-beat packet on channel 1 (last on beat 3) with ch2 valid throughout gives out_sel 1,1,1,2, including a gap cycle where ch1 in_valid=0.
